reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter DW, default 8, register data width (8..32).
REQ-002 SHALL have parameter AW, default 8, address width.
REQ-003 SHALL have parameter N_RW, default 2, number of read/write control registers (1..16).
REQ-004 SHALL have parameter RW_INIT, default 0, reset value of every control register.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  write strobe, one access per cycle high.
REQ-008 SHALL have port rd_en  input  1  read strobe.
REQ-009 SHALL have port addr  input  AW  shared read/write address.
REQ-010 SHALL have port wr_data  input  DW  write data.
REQ-011 SHALL have port evt_in  input  DW  per-bit event pulses that set status bits.
REQ-012 SHALL have port rd_data  output  DW  registered read data.
REQ-013 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-014 SHALL have port err  output  1  one-cycle pulse on an illegal access.
REQ-015 SHALL have port irq  output  1  registered interrupt, level.
REQ-016 SHALL have port ctrl_out  output  N_RW*DW  live control register values; reg k at bits [k*DW +: DW].

Function
REQ-017 SHALL use map: 0x00-0x02 ID read-only (0x49, 0x45, 0x46, zero-extended to DW); 0x03..0x03+N_RW-1 control RW; S=0x03+N_RW status W1C; S+1 irq mask RW; S+2 commit (shadow build only).
REQ-018 SHALL complete a write at the clock edge where wr_en=1; rd_en=1 at edge N SHALL give rd_data and rd_valid=1 after edge N+1.
REQ-019 SHALL hold rd_data between reads; rd_valid SHALL be high exactly one cycle per rd_en.
REQ-020 SHALL, when wr_en and rd_en are both high on the same address, return the pre-write value.
REQ-021 SHALL OR evt_in into status each cycle; writing 1 to a status bit clears it; writing 0 has no effect.
REQ-022 SHALL, when a status bit sees an event and a W1C in the same cycle, leave it set (set wins).
REQ-023 SHALL drive irq one cycle after (status & mask) changes: irq = |(status & mask), registered.
REQ-024 SHALL ignore writes to ID addresses or unmapped addresses and pulse err the next cycle.
REQ-025 SHALL return 0 on reads of unmapped addresses (and of the commit address) with rd_valid=1 and err=1 the next cycle.
REQ-026 SHALL treat wr_en=1 with rd_en=1 to an illegal address as one err pulse, not two.

Reset
REQ-027 SHALL, while rst=1, force control registers to RW_INIT, status and mask to 0, and rd_data, rd_valid, err and irq to 0, immediately and without a clock.
REQ-028 SHALL drop any read in flight when reset is asserted; no rd_valid SHALL follow release.
REQ-029 SHALL accept a new access on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with REG_BANK_SHADOW_EN defined, send control writes to a shadow copy; ctrl_out SHALL update from shadows only on the edge after any write to S+2; reads at control addresses return the shadow.
REQ-031 SHALL, without REG_BANK_SHADOW_EN, update ctrl_out on the edge of the write; S+2 is unmapped (err on access).
REQ-032 SHALL reset shadows to RW_INIT and SHALL commit the shadow value when a control write and a commit occur in the same cycle... not possible (single address); commit SHALL copy shadow contents as of that edge.

Verification
REQ-033 SHALL cover: reset then reads of 0x00, 0x01, 0x02 -> rd_data 0x49, 0x45, 0x46, each with rd_valid one cycle later.
REQ-034 SHALL cover: write 0xA5 to 0x03 with same-cycle read of 0x03 -> read returns RW_INIT; next read returns 0xA5; ctrl_out[7:0]=0xA5 (shadow off).
REQ-035 SHALL cover: evt_in=0x01 one cycle, mask=0x01 -> irq=1; write 0x01 to S while evt_in[0]=1 -> bit stays set; repeat without event -> irq=0 one cycle after clear.
REQ-036 SHALL cover: write 0x55 to 0x01 and read 0x7F -> ID unchanged, rd_data=0, err pulses once per access.
REQ-037 SHALL cover: shadow build, write 0x3C to 0x03 -> ctrl_out unchanged; write S+2 -> ctrl_out[7:0]=0x3C next cycle.
REQ-038 SHALL cover: rst asserted the cycle after rd_en -> no rd_valid; all outputs 0 while rst=1.

Source files
------------

// File: rtl/reg_bank.sv
// reg_bank: ID, control, W1C status and irq-mask registers with registered reads.
// Define REG_BANK_SHADOW_EN to stage control writes in shadows, committed by a write to S+2.
module reg_bank #(
    parameter int            DW      = 8,
    parameter int            AW      = 8,
    parameter int            N_RW    = 2,
    parameter logic [DW-1:0] RW_INIT = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [AW-1:0]      addr,
    input  logic [DW-1:0]      wr_data,
    input  logic [DW-1:0]      evt_in,
    output logic [DW-1:0]      rd_data,
    output logic               rd_valid,
    output logic               err,
    output logic               irq,
    output logic [N_RW*DW-1:0] ctrl_out
);

    localparam logic [31:0]   S_ADDR = 32'(3 + N_RW);
    localparam logic [DW-1:0] ID0    = DW'(8'h49);
    localparam logic [DW-1:0] ID1    = DW'(8'h45);
    localparam logic [DW-1:0] ID2    = DW'(8'h46);

    logic [31:0]     a;
    logic [DW-1:0]   ctrl_q [N_RW];
    logic [DW-1:0]   status_q;
    logic [DW-1:0]   mask_q;
    logic [DW-1:0]   rd_val;
    logic            rd_ok;
    logic            wr_ok;
    logic            wr_stat;
    logic            wr_mask;
    logic [N_RW-1:0] wr_ctrl;
`ifdef REG_BANK_SHADOW_EN
    logic [DW-1:0]   shd_q [N_RW];
    logic            wr_commit;
`endif

    assign a = 32'(addr);

    // Decode once; read and write legality differ only for ID and commit.
    always_comb begin
        rd_val  = '0;
        rd_ok   = 1'b0;
        wr_ok   = 1'b0;
        wr_stat = 1'b0;
        wr_mask = 1'b0;
        wr_ctrl = '0;
`ifdef REG_BANK_SHADOW_EN
        wr_commit = 1'b0;
`endif
        if (a == 32'd0) begin
            rd_ok  = 1'b1;
            rd_val = ID0;
        end else if (a == 32'd1) begin
            rd_ok  = 1'b1;
            rd_val = ID1;
        end else if (a == 32'd2) begin
            rd_ok  = 1'b1;
            rd_val = ID2;
        end else if (a == S_ADDR) begin
            rd_ok   = 1'b1;
            wr_ok   = 1'b1;
            wr_stat = wr_en;
            rd_val  = status_q;
        end else if (a == S_ADDR + 32'd1) begin
            rd_ok   = 1'b1;
            wr_ok   = 1'b1;
            wr_mask = wr_en;
            rd_val  = mask_q;
`ifdef REG_BANK_SHADOW_EN
        end else if (a == S_ADDR + 32'd2) begin
            wr_ok     = 1'b1;
            wr_commit = wr_en;
`endif
        end else begin
            for (int k = 0; k < N_RW; k++) begin
                if (a == 32'(3 + k)) begin
                    rd_ok      = 1'b1;
                    wr_ok      = 1'b1;
                    wr_ctrl[k] = wr_en;
`ifdef REG_BANK_SHADOW_EN
                    rd_val     = shd_q[k];
`else
                    rd_val     = ctrl_q[k];
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_RW; k++) begin
                ctrl_q[k] <= RW_INIT;
`ifdef REG_BANK_SHADOW_EN
                shd_q[k]  <= RW_INIT;
`endif
            end
            status_q <= '0;
            mask_q   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            irq      <= 1'b0;
        end else begin
            // Events are ORed after the clear so a same-cycle event wins.
            status_q <= (wr_stat ? (status_q & ~wr_data) : status_q) | evt_in;
            if (wr_mask) begin
                mask_q <= wr_data;
            end
            for (int k = 0; k < N_RW; k++) begin
`ifdef REG_BANK_SHADOW_EN
                if (wr_ctrl[k]) begin
                    shd_q[k] <= wr_data;
                end
                if (wr_commit) begin
                    ctrl_q[k] <= shd_q[k];
                end
`else
                if (wr_ctrl[k]) begin
                    ctrl_q[k] <= wr_data;
                end
`endif
            end
            irq      <= |(status_q & mask_q);
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_val;
            end
            err <= (wr_en & ~wr_ok) | (rd_en & ~rd_ok);
        end
    end

    for (genvar g = 0; g < N_RW; g++) begin : g_ctrl
        assign ctrl_out[g*DW +: DW] = ctrl_q[g];
    end

endmodule

// File: tb/tb_reg_bank.sv
// tb_reg_bank: directed stimulus with a queue scoreboard checked by a monitor.
// Build with REG_BANK_SHADOW_EN to exercise the shadow/commit variant.
module tb_reg_bank;

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic       er;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  evt_in = '0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        err;
    logic        irq;
    logic [15:0] ctrl_out;
    logic [15:0] exp_c;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    reg_bank #(
        .DW(8),
        .AW(8),
        .N_RW(2),
        .RW_INIT(8'h00)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr(addr),
        .wr_data(wr_data),
        .evt_in(evt_in),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .err(err),
        .irq(irq),
        .ctrl_out(ctrl_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic r, input logic [7:0] d, input logic e);
        exp_t x;
        x.rd = r;
        x.data = d;
        x.er = e;
        sb.push_back(x);
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] ev);
        @(posedge clk);
        #1;
        wr_en = w;
        rd_en = r;
        addr = a;
        wr_data = wd;
        evt_in = ev;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endtask

    // Monitor: every rd_valid or err cycle must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && (rd_valid || err)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual rd_valid=%0b err=%0b required none",
                         rd_valid, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("mon_rd_valid", 32'(rd_valid), 32'(e.rd));
                check("mon_err", 32'(err), 32'(e.er));
                if (e.rd) begin
                    check("mon_rd_data", 32'(rd_data), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        #3;
        check("rst_rd_data", 32'(rd_data), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_ctrl_out", 32'(ctrl_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ID reads
        drive(0, 1, 8'h00, 8'h00, 8'h00); push(1, 8'h49, 0);
        drive(0, 1, 8'h01, 8'h00, 8'h00); push(1, 8'h45, 0);
        drive(0, 1, 8'h02, 8'h00, 8'h00); push(1, 8'h46, 0);
        idle();
        idle();
        check("rd_data_hold", 32'(rd_data), 32'h46);

        // Same-cycle write/read returns the old value
        drive(1, 1, 8'h03, 8'hA5, 8'h00); push(1, 8'h00, 0);
        drive(0, 1, 8'h03, 8'h00, 8'h00); push(1, 8'hA5, 0);
        idle();
`ifdef REG_BANK_SHADOW_EN
        exp_c = 16'h0000;
`else
        exp_c = 16'h00A5;
`endif
        check("ctrl_after_a5", 32'(ctrl_out), 32'(exp_c));

        drive(1, 0, 8'h03, 8'h3C, 8'h00);
        drive(1, 0, 8'h04, 8'h5A, 8'h00);
        idle();
`ifdef REG_BANK_SHADOW_EN
        exp_c = 16'h0000;
`else
        exp_c = 16'h5A3C;
`endif
        check("ctrl_pre_commit", 32'(ctrl_out), 32'(exp_c));
        drive(1, 0, 8'h07, 8'h00, 8'h00);
`ifndef REG_BANK_SHADOW_EN
        push(0, 8'h00, 1);
`endif
        idle();
        check("ctrl_post_commit", 32'(ctrl_out), 32'h5A3C);
        drive(0, 1, 8'h03, 8'h00, 8'h00); push(1, 8'h3C, 0);

        // Status, mask and irq
        drive(1, 0, 8'h06, 8'h01, 8'h00);
        drive(0, 0, 8'h00, 8'h00, 8'h01);
        idle();
        check("irq_lag", 32'(irq), 32'h0);
        idle();
        check("irq_set", 32'(irq), 32'h1);
        drive(1, 0, 8'h05, 8'h01, 8'h01);
        idle();
        idle();
        check("irq_set_wins", 32'(irq), 32'h1);
        drive(0, 1, 8'h05, 8'h00, 8'h00); push(1, 8'h01, 0);
        drive(1, 0, 8'h05, 8'h01, 8'h00);
        idle();
        check("irq_clear_lag", 32'(irq), 32'h1);
        idle();
        check("irq_cleared", 32'(irq), 32'h0);
        drive(0, 1, 8'h05, 8'h00, 8'h00); push(1, 8'h00, 0);
        drive(0, 0, 8'h00, 8'h00, 8'h80);
        drive(1, 0, 8'h05, 8'h00, 8'h00);
        drive(0, 1, 8'h05, 8'h00, 8'h00); push(1, 8'h80, 0);
        idle();
        idle();
        check("irq_unmasked", 32'(irq), 32'h0);
        drive(1, 0, 8'h05, 8'h80, 8'h00);
        drive(0, 1, 8'h05, 8'h00, 8'h00); push(1, 8'h00, 0);
        drive(0, 1, 8'h06, 8'h00, 8'h00); push(1, 8'h01, 0);

        // Illegal accesses
        drive(1, 0, 8'h01, 8'h55, 8'h00); push(0, 8'h00, 1);
        drive(0, 1, 8'h7F, 8'h00, 8'h00); push(1, 8'h00, 1);
        drive(0, 1, 8'h01, 8'h00, 8'h00); push(1, 8'h45, 0);
        drive(1, 1, 8'h7F, 8'h12, 8'h00); push(1, 8'h00, 1);
        drive(0, 1, 8'h07, 8'h00, 8'h00); push(1, 8'h00, 1);
        idle();
        idle();
        idle();
        check("sb_empty_pre_rst", 32'(sb.size()), 32'h0);

        // Reset with a read in flight
        drive(0, 1, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd_en = 1'b0;
        #2;
        check("inrst_rd_valid", 32'(rd_valid), 32'h0);
        check("inrst_rd_data", 32'(rd_data), 32'h0);
        check("inrst_irq", 32'(irq), 32'h0);
        check("inrst_ctrl_out", 32'(ctrl_out), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_en = 1'b1;
        addr = 8'h00;
        push(1, 8'h49, 0);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        drive(0, 1, 8'h03, 8'h00, 8'h00); push(1, 8'h00, 0);
        drive(0, 1, 8'h06, 8'h00, 8'h00); push(1, 8'h00, 0);
        idle();
        idle();
        idle();
        check("sb_empty_end", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
